// File: rtl/chunked_adder_pkg.sv
// Shared types and constants for the chunked adder/subtractor datapath.
package chunked_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/chunked_adder_rca_chunk.sv
// Combinational CHUNK-bit ripple-carry slice; also exposes the carry into its MSB.
module rca_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .sum (sum[i]),
      .cout(c[i+1])
    );
  end

  assign cout = c[CHUNK];
  assign cmsb = c[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per cycle, LSB first, registered carry.
// Optional signed-overflow output ovf is enabled by defining CHUNKED_ADDER_OVF_EN.
module chunked_adder
  import chunked_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CHUNKED_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NCHUNK - 1);

  if (WIDTH % CHUNK != 0) begin : g_bad_width
    $error("chunked_adder: WIDTH must be an integer multiple of CHUNK");
  end

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] next_acc;
  logic [CHUNK-1:0] sl_a;
  logic [CHUNK-1:0] sl_b;
  logic [CHUNK-1:0] sl_sum;
  logic             c_out;
  logic             c_msb;

  assign sl_a = op_a[int'(idx)*CHUNK +: CHUNK];
  assign sl_b = op_b[int'(idx)*CHUNK +: CHUNK];

  rca_chunk #(.CHUNK(CHUNK)) u_rca (
    .a   (sl_a),
    .b   (sl_b),
    .cin (carry),
    .sum (sl_sum),
    .cout(c_out),
    .cmsb(c_msb)
  );

  // Partial results accumulate here so sum only ever shows complete results.
  always_comb begin
    next_acc = acc;
    next_acc[int'(idx)*CHUNK +: CHUNK] = sl_sum;
  end

`ifndef CHUNKED_ADDER_OVF_EN
  logic unused_cmsb;
  assign unused_cmsb = c_msb;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      acc   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef CHUNKED_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
          if (start) begin
            // Subtraction is a + ~b + ~cin, so the borrow-in becomes an inverted carry-in.
            op_a  <= a;
            op_b  <= (sub == OP_SUB) ? ~b : b;
            carry <= (sub == OP_SUB) ? ~cin : cin;
            idx   <= '0;
            acc   <= '0;
            state <= RUN;
            ready <= 1'b0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          acc   <= next_acc;
          carry <= c_out;
          if (idx == LAST) begin
            sum   <= next_acc;
            cout  <= c_out;
`ifdef CHUNKED_ADDER_OVF_EN
            ovf   <= c_out ^ c_msb;
`endif
            idx   <= '0;
            state <= DONE;
            done  <= 1'b1;
            ready <= 1'b1;
            busy  <= 1'b0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_adder.sv
// Scoreboard bench for chunked_adder (32/8 main instance plus an 8/8 single-cycle instance).
module tb_chunked_adder;
  import chunked_adder_pkg::*;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        v;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a, b;
  logic        cin, sub;
  logic        ready, busy, done, cout;
  logic [31:0] sum;
  logic        start8;
  logic [7:0]  a8, b8, sum8;
  logic        cin8, sub8, ready8, busy8, done8, cout8;
`ifdef CHUNKED_ADDER_OVF_EN
  logic        ovf, ovf8;
`endif

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  chunked_adder #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef CHUNKED_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  chunked_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef CHUNKED_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("sum", 64'(sum), 64'(e.s));
        chk("cout", 64'(cout), 64'(e.c));
`ifdef CHUNKED_ADDER_OVF_EN
        chk("ovf", 64'(ovf), 64'(e.v));
`endif
      end
    end
  end

  // Called #1 after a clock edge; returns #1 after the accepting edge.
  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb2, input logic tcin,
                          input logic tsub, input logic [31:0] es, input logic ec, input logic ev,
                          input logic push);
    a = ta; b = tb2; cin = tcin; sub = tsub; start = 1'b1;
    if (push) sb.push_back('{es, ec, ev});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < 20);
  endtask

  initial begin
    int n;
    int dc;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = OP_ADD;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = OP_ADD;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Add wrap-around, latency check
    start_op(32'hFFFF_FFFF, 32'h1, 1'b0, OP_ADD, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("run_busy", 64'(busy), 64'd1);
    chk("run_ready", 64'(ready), 64'd0);
    wait_done(n);
    chk("lat_add", 64'(n), 64'd4);
    @(posedge clk); #1;

    // Subtract with borrow, then without
    start_op(32'd5, 32'd7, 1'b0, OP_SUB, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
    wait_done(n);
    chk("lat_sub1", 64'(n), 64'd4);
    // Back-to-back: start in the done cycle
    start_op(32'd7, 32'd5, 1'b1, OP_SUB, 32'h1, 1'b1, 1'b0, 1'b1);
    wait_done(n);
    chk("lat_b2b1", 64'(n), 64'd4);
    start_op(32'h1234_5678, 32'h1111_1111, 1'b0, OP_ADD, 32'h2345_6789, 1'b0, 1'b0, 1'b1);
    wait_done(n);
    chk("lat_b2b2", 64'(n), 64'd4);
    @(posedge clk); #1;

    // Start pulse and operand changes while busy are ignored
    start_op(32'h0000_FFFF, 32'h1, 1'b0, OP_ADD, 32'h0001_0000, 1'b0, 1'b0, 1'b1);
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; cin = 1'b1; sub = OP_SUB; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 32'hAAAA_AAAA;
    wait_done(n);
    chk("lat_ignore", 64'(n), 64'd3);
    dc = done_cnt;
    repeat (8) @(posedge clk);
    #1;
    chk("no_extra_done", 64'(done_cnt), 64'(dc + 1));
    chk("idle_ready", 64'(ready), 64'd1);

    // Reset during second RUN cycle
    start_op(32'h0F0F_0F0F, 32'h0101_0101, 1'b0, OP_ADD, 32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mrst_sum", 64'(sum), 64'd0);
    chk("mrst_cout", 64'(cout), 64'd0);
    chk("mrst_ready", 64'(ready), 64'd1);
    chk("mrst_busy", 64'(busy), 64'd0);
    dc = done_cnt;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("mrst_no_done", 64'(done_cnt), 64'(dc));
    start_op(32'h10, 32'h20, 1'b0, OP_ADD, 32'h30, 1'b0, 1'b0, 1'b1);
    wait_done(n);
    chk("lat_after_rst", 64'(n), 64'd4);
    @(posedge clk); #1;

    // Signed overflow cases
    start_op(32'h7FFF_FFFF, 32'h1, 1'b0, OP_ADD, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
    wait_done(n);
    start_op(32'h8000_0000, 32'h1, 1'b0, OP_SUB, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1);
    wait_done(n);
    @(posedge clk); #1;
    chk("sum_hold", 64'(sum), 64'h7FFF_FFFF);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    // Single-cycle configuration
    a8 = 8'hC8; b8 = 8'h64; cin8 = 1'b0; sub8 = OP_ADD; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    chk("w8_busy", 64'(busy8), 64'd1);
    @(posedge clk); #1;
    chk("w8_done", 64'(done8), 64'd1);
    chk("w8_sum", 64'(sum8), 64'h2C);
    chk("w8_cout", 64'(cout8), 64'd1);
`ifdef CHUNKED_ADDER_OVF_EN
    chk("w8_ovf", 64'(ovf8), 64'd0);
`endif
    @(posedge clk); #1;
    chk("w8_done_pulse", 64'(done8), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
